// File: rtl/mem_sweep_pkg.sv
// Shared types and constants for the memory sweep controller and its compare stage.
package mem_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic MODE_FILL  = 1'b0;
    localparam logic MODE_CHECK = 1'b1;

    localparam int                   ERR_CNT_W   = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/mem_sweep_cmp.sv
// One-stage expected-data pipeline that lines up with the RAM read latency,
// plus mismatch counting and first-error capture.
module mem_sweep_cmp
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM = 18,
    parameter int ADDR_W  = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 rd_vld,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [WID_MEM-1:0]   rd_exp,
    input  logic [WID_MEM-1:0]   mem_dout,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic                 err_seen
);

    logic                 vld_q, vld_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WID_MEM-1:0]   exp_q, exp_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]    first_q, first_d;
    logic                 seen_q, seen_d;
    logic                 mismatch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_q     <= 1'b0;
            addr_q    <= '0;
            exp_q     <= '0;
            err_cnt_q <= '0;
            first_q   <= '0;
            seen_q    <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            addr_q    <= addr_d;
            exp_q     <= exp_d;
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
            seen_q    <= seen_d;
        end
    end

    always_comb begin
        vld_d     = rd_vld;
        addr_d    = rd_addr;
        exp_d     = rd_exp;
        err_cnt_d = err_cnt_q;
        first_d   = first_q;
        seen_d    = seen_q;
        mismatch  = vld_q && (mem_dout != exp_q);
        if (clear) begin
            err_cnt_d = '0;
            first_d   = '0;
            seen_d    = 1'b0;
        end else if (mismatch) begin
            if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (!seen_q) begin
                first_d = addr_q;
                seen_d  = 1'b1;
            end
        end
    end

    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_q;
    assign err_seen       = seen_q;

endmodule

// File: rtl/mem_sweep_ctrl.sv
// RAM fill/check sweep controller: writes seed^addr to every word, or reads
// every word back and counts words that differ from seed^addr.
//
// state    | meaning
// IDLE     | waiting for start
// FILL     | one write per cycle, ascending address
// READ     | one read per cycle, ascending address
// DRAIN    | compare of the last read word
// DONE     | one-cycle done pulse
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int WID_MEM   = 18,
    parameter int DEPTH_MEM = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [WID_MEM-1:0]   seed,
    output logic [ADDR_W-1:0]    mem_raddr,
    output logic                 mem_ren,
    output logic [ADDR_W-1:0]    mem_waddr,
    output logic [WID_MEM-1:0]   mem_din,
    output logic                 mem_we,
    input  logic [WID_MEM-1:0]   mem_dout,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic                 err_seen
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH_MEM - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WID_MEM-1:0] seed_q, seed_d;
    logic [WID_MEM-1:0] pat;
    logic               cmp_clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            seed_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            seed_q  <= seed_d;
        end
    end

    // Address advances only inside a sweep and parks at zero when the last word is reached.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        seed_d  = seed_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d  = seed;
                    addr_d  = '0;
                    state_d = (mode == MODE_CHECK) ? ST_READ : ST_FILL;
                end
            end
            ST_FILL, ST_READ: begin
                if (addr_q == ADDR_LAST) begin
                    addr_d  = '0;
                    state_d = (state_q == ST_FILL) ? ST_DONE : ST_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign pat       = seed_q ^ WID_MEM'(addr_q);
    assign cmp_clear = (state_q == ST_IDLE) && start && (mode == MODE_CHECK);

    always_comb begin
        mem_we    = 1'b0;
        mem_ren   = 1'b0;
        mem_waddr = '0;
        mem_raddr = '0;
        mem_din   = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_FILL: begin
                mem_we    = 1'b1;
                mem_waddr = addr_q;
                mem_din   = pat;
                busy      = 1'b1;
            end
            ST_READ: begin
                mem_ren   = 1'b1;
                mem_raddr = addr_q;
                busy      = 1'b1;
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    mem_sweep_cmp #(
        .WID_MEM (WID_MEM),
        .ADDR_W  (ADDR_W)
    ) u_cmp (
        .clk            (clk),
        .reset          (reset),
        .clear          (cmp_clear),
        .rd_vld         (mem_ren),
        .rd_addr        (addr_q),
        .rd_exp         (pat),
        .mem_dout       (mem_dout),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr),
        .err_seen       (err_seen)
    );

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
// Bench for mem_sweep_ctrl: a 16-word instance on a behavioural RAM and a
// 4096-word instance reading an all-ones RAM.
module tb_mem_sweep_ctrl;

    localparam int W  = 18;
    localparam int D  = 16;
    localparam int A  = 4;
    localparam int DK = 4096;
    localparam int AK = 12;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          start, mode;
    logic [W-1:0]  seed;
    logic [A-1:0]  raddr, waddr;
    logic          ren, we, busy, done, err_seen;
    logic [W-1:0]  din, dout;
    logic [15:0]   err_cnt;
    logic [A-1:0]  first_err;

    logic          start_k, mode_k;
    logic [W-1:0]  seed_k;
    logic [AK-1:0] raddr_k, waddr_k;
    logic          ren_k, we_k, busy_k, done_k, err_seen_k;
    logic [W-1:0]  din_k;
    logic [W-1:0]  dout_k;
    logic [15:0]   err_cnt_k;
    logic [AK-1:0] first_err_k;

    mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(D), .ADDR_W(A)) u_dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .mem_raddr(raddr), .mem_ren(ren), .mem_waddr(waddr), .mem_din(din),
        .mem_we(we), .mem_dout(dout), .busy(busy), .done(done),
        .err_cnt(err_cnt), .first_err_addr(first_err), .err_seen(err_seen)
    );

    mem_sweep_ctrl #(.WID_MEM(W), .DEPTH_MEM(DK), .ADDR_W(AK)) u_dut_k (
        .clk(clk), .reset(reset), .start(start_k), .mode(mode_k), .seed(seed_k),
        .mem_raddr(raddr_k), .mem_ren(ren_k), .mem_waddr(waddr_k), .mem_din(din_k),
        .mem_we(we_k), .mem_dout(dout_k), .busy(busy_k), .done(done_k),
        .err_cnt(err_cnt_k), .first_err_addr(first_err_k), .err_seen(err_seen_k)
    );

    // Behavioural 1-cycle-latency RAM; flip[] corrupts read data per word.
    logic [W-1:0] ram  [D];
    logic [W-1:0] flip [D];
    always @(posedge clk) begin
        if (we)  ram[waddr] <= din;
        if (ren) dout <= ram[raddr] ^ flip[raddr];
    end
    assign dout_k = '1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0] ref_mem [D];
    int           ref_cnt = 0;
    int           ref_first = 0;
    int           ref_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_results(input string tag);
        chk({tag, "_err_cnt"},  32'(err_cnt),   32'(ref_cnt));
        chk({tag, "_err_seen"}, 32'(err_seen),  32'(ref_seen));
        chk({tag, "_first"},    32'(first_err), 32'(ref_first));
    endtask

    // Runs one sweep on the 16-word DUT and checks every cycle against the rules.
    // poke_rel: cycle (relative to start) at which start is pulsed again, 0 = never.
    task automatic sweep16(input logic m, input logic [W-1:0] s, input int poke_rel);
        int exp_done;
        exp_done = m ? D + 2 : D + 1;
        @(negedge clk);
        start = 1'b1; mode = m; seed = s;
        @(negedge clk);
        start = 1'b0; mode = ~m; seed = W'($urandom);
        for (int rel = 1; rel <= exp_done; rel++) begin
            if (rel > 1) @(negedge clk);
            if (rel <= D) begin
                if (!m) begin
                    chk("fill_we",    32'(we),    1);
                    chk("fill_ren",   32'(ren),   0);
                    chk("fill_waddr", 32'(waddr), 32'(rel - 1));
                    chk("fill_din",   32'(din),   32'(s ^ W'(rel - 1)));
                end else begin
                    chk("read_ren",   32'(ren),   1);
                    chk("read_we",    32'(we),    0);
                    chk("read_raddr", 32'(raddr), 32'(rel - 1));
                end
                chk("sweep_busy", 32'(busy), 1);
                chk("sweep_done", 32'(done), 0);
            end else if (rel == exp_done) begin
                chk("done_pulse", 32'(done), 1);
                chk("done_busy",  32'(busy), 0);
                chk("done_we_ren", 32'({we, ren}), 0);
            end else begin
                chk("drain_busy",  32'(busy), 1);
                chk("drain_done",  32'(done), 0);
                chk("drain_we_ren", 32'({we, ren}), 0);
            end
            start = (poke_rel != 0 && rel == poke_rel);
            mode  = 1'($urandom);
        end
        start = 1'b0;
        if (!m) begin
            for (int a = 0; a < D; a++) ref_mem[a] = s ^ W'(a);
        end else begin
            ref_cnt = 0; ref_seen = 0; ref_first = 0;
            for (int a = 0; a < D; a++) begin
                if ((ref_mem[a] ^ flip[a]) != (s ^ W'(a))) begin
                    if (ref_seen == 0) ref_first = a;
                    ref_seen = 1;
                    ref_cnt++;
                end
            end
        end
        chk_results(m ? "check" : "fill_keep");
        @(negedge clk);
        chk("post_done", 32'(done), 0);
        chk("post_busy", 32'(busy), 0);
        chk("post_we_ren", 32'({we, ren}), 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({busy, done, we, ren, err_seen}), 0);
        chk({tag, "_addr"}, 32'({raddr, waddr, first_err}), 0);
        chk({tag, "_din"}, 32'(din), 0);
        chk({tag, "_cnt"}, 32'(err_cnt), 0);
    endtask

    initial begin
        int got_rel;
        start = 0; mode = 0; seed = '0;
        start_k = 0; mode_k = 0; seed_k = '0;
        for (int a = 0; a < D; a++) flip[a] = '0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b1;

        // Fixed seed fill, then a clean check
        sweep16(1'b0, 18'h154AA, 0);
        chk("ram_word5", 32'(ram[5]), 32'h154AF);
        sweep16(1'b1, 18'h154AA, 0);

        // Two corrupted words
        flip[3] = 18'h00001;
        flip[9] = 18'h20000;
        sweep16(1'b1, 18'h154AA, 0);
        chk("corrupt_cnt", 32'(err_cnt), 2);
        chk("corrupt_first", 32'(first_err), 3);

        // A fill start leaves the previous check results in place
        sweep16(1'b0, W'($urandom), 5);
        for (int a = 0; a < D; a++) flip[a] = '0;

        // Randomized fill/corrupt/check rounds, some with start pokes while busy
        for (int it = 0; it < 6; it++) begin
            logic [W-1:0] s;
            int nflip;
            s = W'($urandom);
            sweep16(1'b0, s, (it % 2 == 0) ? int'($urandom_range(1, D)) : 0);
            nflip = int'($urandom_range(0, 3));
            for (int a = 0; a < D; a++) flip[a] = '0;
            for (int k = 0; k < nflip; k++)
                flip[$urandom_range(0, D - 1)] = W'($urandom_range(1, (1 << W) - 1));
            sweep16(1'b1, ((it % 3) == 2) ? W'($urandom) : s,
                    (it % 2 == 1) ? int'($urandom_range(1, D + 1)) : 0);
        end
        for (int a = 0; a < D; a++) flip[a] = '0;

        // Reset in the middle of a fill, at address 7
        @(negedge clk);
        start = 1'b1; mode = 1'b0; seed = W'($urandom);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_waddr", 32'(waddr), 7);
        chk("abort_we", 32'(we), 1);
        #1 reset = 1'b0;
        #1 chk_all_zero("abort");
        got_rel = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) got_rel = 1;
        end
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) got_rel = 1;
        end
        chk("abort_no_done", 32'(got_rel), 0);
        ref_cnt = 0; ref_seen = 0; ref_first = 0;
        chk_results("after_abort");
        sweep16(1'b0, W'($urandom), 0);
        sweep16(1'b1, seed, 0);

        // Full-depth check against an all-ones RAM
        @(negedge clk);
        start_k = 1'b1; mode_k = 1'b1; seed_k = '0;
        @(negedge clk);
        start_k = 1'b0;
        got_rel = 0;
        for (int rel = 1; rel <= DK + 20 && got_rel == 0; rel++) begin
            if (rel > 1) @(negedge clk);
            if (done_k) got_rel = rel;
        end
        chk("k_done_rel", 32'(got_rel), DK + 2);
        chk("k_err_cnt", 32'(err_cnt_k), DK);
        chk("k_first", 32'(first_err_k), 0);
        chk("k_err_seen", 32'(err_seen_k), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
